// File: rtl/mfsk_ber_monitor.sv
// Symbol/bit error monitor for the M-FSK modem chain.
// A reference FIFO aligns transmitted symbols with demodulated ones; after a
// startup skip, each aligned pair is compared and tallied over a window.
module mfsk_ber_monitor #(
    parameter int unsigned SYM_BITS   = 3,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned SKIP       = 1,
    parameter int unsigned WINDOW     = 400
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ref_valid,
    input  logic [SYM_BITS-1:0]  ref_symbol,
    input  logic                 rx_valid,
    input  logic [SYM_BITS-1:0]  rx_symbol,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic [CNT_WIDTH-1:0] bit_error_count,
    output logic [CNT_WIDTH-1:0] total_count,
    output logic                 fifo_overflow,
    output logic                 rx_underflow
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned CW1 = CNT_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] WIN_C   = CNT_WIDTH'(WINDOW);
    localparam logic [7:0]           SKIP_C  = 8'(SKIP);

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        wr_q, wr_d;
    logic [PW-1:0]        rd_q, rd_d;
    logic [7:0]           skip_q, skip_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [CNT_WIDTH-1:0] bit_q, bit_d;
    logic [CNT_WIDTH-1:0] tot_q, tot_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [SYM_BITS-1:0]  mem_q [FIFO_DEPTH];

    logic                 active_c;
    logic                 empty_c;
    logic                 full_c;
    logic                 push_c;
    logic                 pop_c;
    logic [SYM_BITS-1:0]  head_c;
    logic [SYM_BITS-1:0]  diff_c;

    // Number of differing bits, widened to counter width plus carry.
    function automatic logic [CNT_WIDTH:0] popcnt(input logic [SYM_BITS-1:0] v);
        logic [CNT_WIDTH:0] n;
        n = '0;
        for (int unsigned i = 0; i < SYM_BITS; i++) begin
            n = n + CW1'(v[i]);
        end
        return n;
    endfunction

    // Saturating accumulate; the carry bit flags overflow.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH:0]   inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + inc;
        return sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];
    endfunction

    // Next-state: FIFO bookkeeping, skip/compare tallies and window control.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        skip_d  = skip_q;
        err_d   = err_q;
        bit_d   = bit_q;
        tot_d   = tot_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;

        active_c = (state_q == ST_SKIP) || (state_q == ST_RUN);
        empty_c  = (wr_q == rd_q);
        full_c   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        head_c   = mem_q[rd_q[AW-1:0]];
        diff_c   = head_c ^ rx_symbol;

        if (start) begin
            wr_d    = '0;
            rd_d    = '0;
            skip_d  = '0;
            err_d   = '0;
            bit_d   = '0;
            tot_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            state_d = (SKIP > 0) ? ST_SKIP : ST_RUN;
        end else if (active_c) begin
            pop_c  = rx_valid && !empty_c;
            push_c = ref_valid && (!full_c || pop_c);
            if (rx_valid && empty_c) begin
                udf_d = 1'b1;
            end
            if (ref_valid && full_c && !pop_c) begin
                ovf_d = 1'b1;
            end
            if (pop_c) begin
                rd_d = rd_q + PW'(1);
            end
            if (push_c) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop_c && (state_q == ST_SKIP)) begin
                skip_d = skip_q + 8'd1;
                if (skip_d == SKIP_C) begin
                    state_d = ST_RUN;
                end
            end else if (pop_c && (tot_q != CNT_MAX)) begin
                tot_d = tot_q + CNT_WIDTH'(1);
                err_d = sat_add(err_q, CW1'(diff_c != '0));
                bit_d = sat_add(bit_q, popcnt(diff_c));
                if ((WINDOW != 0) && (tot_d == WIN_C)) begin
                    state_d = ST_DONE;
                end
            end
        end

        busy_d = (state_d == ST_SKIP) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            skip_q  <= '0;
            err_q   <= '0;
            bit_q   <= '0;
            tot_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            tot_q   <= tot_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Reference FIFO storage; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q[AW-1:0]] <= ref_symbol;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error_count     = err_q;
    assign bit_error_count = bit_q;
    assign total_count     = tot_q;
    assign fifo_overflow   = ovf_q;
    assign rx_underflow    = udf_q;

endmodule

// File: tb/tb_mfsk_ber_monitor.sv
// Directed bench for mfsk_ber_monitor: three parameterisations driven from one
// sequence, with a queue scoreboard holding the pending reference symbols.
module tb_mfsk_ber_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       st_s [3];
    logic       rv_s [3];
    logic       xv_s [3];
    logic [3:0] r_s  [3];
    logic [3:0] x_s  [3];
    logic       bz   [3];
    logic       dn   [3];
    logic       ov   [3];
    logic       ud   [3];
    logic [31:0] ea, ba, ta, ec, bc, tc;
    logic [3:0]  eb, bb, tb4;

    int checks = 0;
    int errors = 0;

    // Instance 0: 8-FSK, skip 1, window 8.
    mfsk_ber_monitor #(.SYM_BITS(3), .FIFO_DEPTH(16), .CNT_WIDTH(32), .SKIP(1), .WINDOW(8)) u_a (
        .clk(clk), .reset(reset), .start(st_s[0]),
        .ref_valid(rv_s[0]), .ref_symbol(r_s[0][2:0]),
        .rx_valid(xv_s[0]), .rx_symbol(x_s[0][2:0]),
        .busy(bz[0]), .done(dn[0]),
        .error_count(ea), .bit_error_count(ba), .total_count(ta),
        .fifo_overflow(ov[0]), .rx_underflow(ud[0]));

    // Instance 1: 4-FSK, 4-bit counters, free-running.
    mfsk_ber_monitor #(.SYM_BITS(2), .FIFO_DEPTH(16), .CNT_WIDTH(4), .SKIP(0), .WINDOW(0)) u_b (
        .clk(clk), .reset(reset), .start(st_s[1]),
        .ref_valid(rv_s[1]), .ref_symbol(r_s[1][1:0]),
        .rx_valid(xv_s[1]), .rx_symbol(x_s[1][1:0]),
        .busy(bz[1]), .done(dn[1]),
        .error_count(eb), .bit_error_count(bb), .total_count(tb4),
        .fifo_overflow(ov[1]), .rx_underflow(ud[1]));

    // Instance 2: 16-FSK, free-running, used for FIFO edge cases.
    mfsk_ber_monitor #(.SYM_BITS(4), .FIFO_DEPTH(16), .CNT_WIDTH(32), .SKIP(0), .WINDOW(0)) u_c (
        .clk(clk), .reset(reset), .start(st_s[2]),
        .ref_valid(rv_s[2]), .ref_symbol(r_s[2]),
        .rx_valid(xv_s[2]), .rx_symbol(x_s[2]),
        .busy(bz[2]), .done(dn[2]),
        .error_count(ec), .bit_error_count(bc), .total_count(tc),
        .fifo_overflow(ov[2]), .rx_underflow(ud[2]));

    // Reference model: 0 idle, 1 skip, 2 run, 3 done.
    int     p_skip [3] = '{1, 0, 0};
    int     p_win  [3] = '{8, 0, 0};
    longint p_max  [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
    int     p_mask [3] = '{7, 3, 15};
    int     m_state [3];
    int     m_skip  [3];
    longint m_err   [3];
    longint m_bit   [3];
    longint m_tot   [3];
    bit     m_ovf   [3];
    bit     m_udf   [3];
    int     q0 [$];
    int     q1 [$];
    int     q2 [$];

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int k, input int v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic void model_clear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
        m_skip[k] = 0; m_err[k] = 0; m_bit[k] = 0; m_tot[k] = 0;
        m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_edge(input int k, input bit st, input bit rv, input int r,
                                       input bit xv, input int x);
        int  sz;
        int  h;
        bit  pop_ok;
        bit  full;
        if (st) begin
            model_clear(k);
            m_state[k] = (p_skip[k] > 0) ? 1 : 2;
            return;
        end
        if (m_state[k] != 1 && m_state[k] != 2) return;
        sz     = qsize(k);
        pop_ok = xv && (sz > 0);
        full   = (sz == 16);
        if (xv && sz == 0) m_udf[k] = 1'b1;
        if (rv && full && !pop_ok) m_ovf[k] = 1'b1;
        if (pop_ok) begin
            h = qpop(k);
            if (m_state[k] == 1) begin
                m_skip[k]++;
                if (m_skip[k] == p_skip[k]) m_state[k] = 2;
            end else if (m_tot[k] != p_max[k]) begin
                m_tot[k]++;
                if (h != (x & p_mask[k])) m_err[k] = sat(m_err[k] + 1, p_max[k]);
                m_bit[k] = sat(m_bit[k] + $countones(h ^ (x & p_mask[k])), p_max[k]);
                if (p_win[k] != 0 && m_tot[k] == p_win[k]) m_state[k] = 3;
            end
        end
        if (rv && (!full || pop_ok)) qpush(k, r & p_mask[k]);
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_out(input int k);
        logic [31:0] e, b, t;
        case (k)
            0:       begin e = ea;        b = ba;        t = ta;         end
            1:       begin e = 32'(eb);   b = 32'(bb);   t = 32'(tb4);   end
            default: begin e = ec;        b = bc;        t = tc;         end
        endcase
        chk("busy",      k, 64'(bz[k]), 64'(m_state[k] == 1 || m_state[k] == 2));
        chk("done",      k, 64'(dn[k]), 64'(m_state[k] == 3));
        chk("error",     k, 64'(e),     64'(m_err[k]));
        chk("bit_error", k, 64'(b),     64'(m_bit[k]));
        chk("total",     k, 64'(t),     64'(m_tot[k]));
        chk("overflow",  k, 64'(ov[k]), 64'(m_ovf[k]));
        chk("underflow", k, 64'(ud[k]), 64'(m_udf[k]));
    endtask

    task automatic step(input int k, input bit st, input bit rv, input int r, input bit xv, input int x);
        st_s[k] = st; rv_s[k] = rv; r_s[k] = 4'(r); xv_s[k] = xv; x_s[k] = 4'(x);
        @(posedge clk);
        model_edge(k, st, rv, r, xv, x);
        #1;
        st_s[k] = 1'b0; rv_s[k] = 1'b0; xv_s[k] = 1'b0;
        check_out(k);
    endtask

    task automatic do_reset(input bit with_start);
        reset = 1'b1;
        st_s[0] = with_start;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            model_clear(k);
            m_state[k] = 0;
        end
        #1;
        reset = 1'b0;
        st_s[0] = 1'b0;
        for (int k = 0; k < 3; k++) check_out(k);
    endtask

    int seq [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st_s[k] = 1'b0; rv_s[k] = 1'b0; xv_s[k] = 1'b0; r_s[k] = '0; x_s[k] = '0;
            m_state[k] = 0;
        end
        do_reset(1'b0);

        // Idle ignores traffic.
        step(0, 0, 1, 3, 1, 3);

        // Clean window: rx trails ref by one symbol.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, i < 9, (i < 9) ? seq[i] : 0, i > 0, (i > 0) ? seq[i-1] : 0);
        chk("t1_done", 0, 64'(dn[0]), 64'd1);
        chk("t1_total", 0, 64'(ta), 64'd8);
        step(0, 0, 1, 5, 1, 6);

        // Single 3-bit symbol error at the third compared symbol (ref 010, rx 101).
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            int rx;
            rx = (i > 0) ? seq[i-1] : 0;
            if (i == 4) rx = 5;
            step(0, 0, i < 9, (i < 9) ? seq[i] : 0, i > 0, rx);
        end
        chk("t2_error", 0, 64'(ea), 64'd1);
        chk("t2_bit_error", 0, 64'(ba), 64'd3);

        // Restart mid-run at total 5; start-cycle valids are ignored.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, i, i > 0, i - 1);
        chk("t5_total", 0, 64'(ta), 64'd5);
        step(0, 1, 1, 2, 1, 2);
        chk("t5_restart_total", 0, 64'(ta), 64'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("t5_fifo_empty", 0, 64'(ud[0]), 64'd1);
        do_reset(1'b1);
        chk("t5_reset_busy", 0, 64'(bz[0]), 64'd0);

        // Overflow on the 17th push, 16 ordered pops, then underflow.
        step(2, 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(2, 0, 1, i, 0, 0);
        chk("t3_overflow", 2, 64'(ov[2]), 64'd1);
        for (int i = 0; i < 16; i++) step(2, 0, 0, 0, 1, i);
        chk("t3_error", 2, 64'(ec), 64'd0);
        step(2, 0, 0, 0, 1, 0);
        chk("t3_total", 2, 64'(tc), 64'd16);

        // Push and rx on an empty FIFO: no bypass.
        step(2, 1, 0, 0, 0, 0);
        step(2, 0, 1, 9, 1, 9);
        chk("t4_underflow", 2, 64'(ud[2]), 64'd1);
        step(2, 0, 0, 0, 1, 9);
        chk("t4_total", 2, 64'(tc), 64'd1);

        // 4-bit counters saturate at 15 with one-bit mismatches.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 21; i++) step(1, 0, i < 20, i & 3, i > 0, ((i - 1) & 3) ^ 1);
        chk("t6_error", 1, 64'(eb), 64'd15);
        chk("t6_bit_error", 1, 64'(bb), 64'd15);
        chk("t6_total", 1, 64'(tb4), 64'd15);
        chk("t6_done", 1, 64'(dn[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfsk_ber_monitor.md
Name: mfsk_ber_monitor

Overview:
- Synthesizable, parametrised symbol-error and bit-error monitor for the M-FSK modem chain (2/4/8/16-FSK via SYM_BITS).
- Replaces ad-hoc bench-side comparison of transmitted and demodulated symbols.
- Taps the symbol stream entering the modulator and the symbol stream leaving the demodulator.
- Aligns the two streams through an internal reference FIFO, which absorbs arbitrary modem latency. Counts symbol, bit and total comparisons over a programmable window.

Parameters:
- SYM_BITS, 3, bits per symbol (1..4; M = 2^SYM_BITS).
- FIFO_DEPTH, 16, reference FIFO entries; power of two, 2..256.
- CNT_WIDTH, 32, width of all counters.
- SKIP, 1, leading received symbols discarded after start (startup transient); 0..255.
- WINDOW, 400, compared symbols per measurement; 0 = free-running.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; clears and (re)starts a measurement.
- ref_valid  in  1  ref_symbol valid this cycle (push).
- ref_symbol  in  SYM_BITS  transmitted symbol.
- rx_valid  in  1  rx_symbol valid this cycle (pop and compare).
- rx_symbol  in  SYM_BITS  demodulated symbol.
- busy  out  1  measurement in progress (SKIP or RUN).
- done  out  1  window complete; held until start or reset.
- error_count  out  CNT_WIDTH  symbols with rx != ref.
- bit_error_count  out  CNT_WIDTH  sum of popcount(rx ^ ref).
- total_count  out  CNT_WIDTH  symbols compared.
- fifo_overflow  out  1  sticky: ref push dropped because FIFO full.
- rx_underflow  out  1  sticky: rx_valid with FIFO empty.

Behaviour:
- Reset, sampled on the clk edge:
  - state = IDLE, FIFO empty.
  - All counters and flags, busy and done = 0.
  - reset has priority over start.
- States: IDLE, SKIP, RUN, DONE.
- IDLE:
  - ref_valid and rx_valid are ignored.
  - start -> SKIP if SKIP > 0, else RUN.
- start, in any state, on the sampled edge:
  - Counters, flags and FIFO are cleared, and the skip counter is zeroed.
  - Next state is SKIP (or RUN if SKIP = 0).
  - ref_valid and rx_valid on the start cycle are ignored.
- SKIP and RUN, FIFO handling:
  - ref_valid pushes ref_symbol.
  - rx_valid pops the head.
  - Push and pop in the same cycle are both performed.
- Full FIFO: a push without a simultaneous pop is dropped and fifo_overflow is set. Push plus pop while full succeeds, with no overflow.
- Empty FIFO:
  - rx_valid sets rx_underflow and the rx symbol is dropped.
  - Nothing is counted, including the skip counter.
  - Any simultaneous push still completes; there is no bypass.
- SKIP: each successful pop increments the skip counter without comparing. The pop that makes the counter equal SKIP moves the state to RUN.
- RUN, on each successful pop:
  - total_count += 1.
  - error_count += (head != rx_symbol).
  - bit_error_count += popcount(head ^ rx_symbol).
  - All counters update on the same edge that samples rx_valid.
- Saturation:
  - Each counter saturates at 2^CNT_WIDTH-1.
  - Once total_count is saturated, no counter changes further.
- Window end: when WINDOW != 0 and the pop makes total_count == WINDOW, the state becomes DONE on that edge.
- DONE:
  - done = 1, busy = 0.
  - Counters, flags and FIFO are frozen; inputs are ignored until start.
- busy = 1 exactly in SKIP and RUN. All outputs are registered.
- SYM_BITS = 1: bit_error_count equals error_count.

Test Plan:
- SYM_BITS=3, SKIP=1, WINDOW=8, start. Push refs 0,0,1,2,...,7 and pop rx with the same sequence one symbol later -> done=1; total=8; error=0; bit_error=0; no flags.
- Same setup with compared symbol #3 as rx=3'b101 against ref=3'b010 -> error_count=1, bit_error_count=3, total=8.
- FIFO_DEPTH=16, RUN, push 17 refs (values 0..16) with no rx -> fifo_overflow=1 after the 17th. Then 16 pops return 0..15, and the next pop sets rx_underflow, total unchanged.
- RUN with an empty FIFO: rx_valid and ref_valid in the same cycle -> rx_underflow=1, total_count unchanged. The next rx pop compares against the pushed ref.
- Restart: start pulse at total_count=5 mid-RUN -> next cycle all counters 0, flags 0, FIFO empty, state SKIP, busy=1, done=0. Same check with reset asserted together with start -> IDLE, busy=0.
- CNT_WIDTH=4, SKIP=0, WINDOW=0, 20 pops all mismatched by one bit -> error_count=15, bit_error_count=15, total_count=15, all held; done stays 0.
